phase_accumulator_nco: RTL and testbench
========================================

// Module: phase_accumulator_nco
// PURPOSE
//   Numerically controlled oscillator that generates the PSI square wave measured by the frequency regulator.
//   - Closes the loop: regulator adjustedDiv -> freq_word here; PSI here -> regulator PSI input.
//   - Larger freq_word gives a shorter high phase, so the regulator's +1/-1 steps converge on setPeriod.
//   - A new word is applied only at accumulator wrap, so the phase stays continuous.
// PARAMETERS
//   ACC_W      16     accumulator width; PSI = acc[ACC_W-1]; nominal period = 2^ACC_W / word clocks
//   INIT_WORD  8'h7F  active_word value after reset; matches the regulator's reset adjustedDiv
//   PER_W      16     width of period_len and of the internal period counter
// PORTS
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous, active-high reset
//   en           in   1      run enable; 0 parks the oscillator
//   freq_word    in   8      requested phase increment (from adjustedDiv)
//   PSI          out  1      oscillator output = acc[ACC_W-1]; driven directly from a register bit
//   wrap_tick    out  1      one-cycle pulse, registered, on accumulator carry-out
//   phase        out  ACC_W  current accumulator value
//   active_word  out  8      increment currently in use
//   period_len   out  PER_W  clocks in the last completed period
//   stalled      out  1      1 while in RUN with active_word == 0
// BEHAVIOUR
//   Reset (async): acc=0, PSI=0, wrap_tick=0, period_len=0, per_cnt=0, active_word=INIT_WORD, stalled=0, state=IDLE.
//   States: IDLE, RUN (one state bit).
//   IDLE:
//     - acc, per_cnt and wrap_tick are held at 0.
//     - When en=1 at a clock edge: go to RUN, active_word<=freq_word, acc<=0, per_cnt<=0. No add occurs on this edge.
//   RUN, each edge with en=1:
//     - sum = {1'b0,acc} + word zero-extended to ACC_W+1 bits; acc<=sum[ACC_W-1:0]; carry = sum[ACC_W].
//     - carry=1 (wrap): wrap_tick<=1; period_len<=per_cnt+1; per_cnt<=0; active_word<=freq_word (the only reload point).
//     - carry=0: wrap_tick<=0; per_cnt<=per_cnt+1, saturating at all-ones (period_len then reports all-ones on the next wrap).
//   Zero word:
//     - active_word==0 in RUN: acc frozen, PSI constant, stalled=1.
//     - In this case active_word reloads from freq_word on every edge, so the block leaves the stall one cycle after a nonzero word appears.
//   Leaving RUN: en=0 at an edge -> go to IDLE; acc<=0 (so PSI=0 next cycle), wrap_tick<=0, per_cnt<=0.
//     - period_len and active_word keep their values.
//     - If the regulator sees this 1->0 PSI edge, it treats it as a normal falling edge.
//   Simultaneous wrap and en=0: en=0 wins. No tick, no reload, period_len unchanged.
//   freq_word changes between wraps are ignored, except in the zero-word stall.
//   Async rst mid-period: all outputs return to their reset values immediately; the partial period is discarded.
//   Latency:
//     - PSI, phase and wrap_tick change on the edge that updates acc.
//     - High time of PSI = ceil-ish(2^(ACC_W-1)/word); the exact count follows from the accumulated phase.
// TESTING
//   1. rst, en=1, freq_word=8'h80 -> PSI low 256 clk, high 256 clk; wrap_tick every 512 clk; period_len=512; phase steps by 0x80.
//   2. Running at 8'h80, switch freq_word to 8'h40 mid-period -> current period still 512, next period 1024; active_word changes on the wrap edge only.
//   3. freq_word=8'h00 reaches a wrap reload -> stalled=1, phase frozen; then freq_word=8'h80 -> stalled=0 one clk later, phase resumes +0x80/clk.
//   4. en=0 while PSI=1 -> next clk PSI=0, phase=0, no wrap_tick; en=1 again -> first period_len=512 (word 8'h80).
//   5. Async rst asserted mid-high -> PSI=0, phase=0, active_word=8'h7F, period_len=0 without waiting for a clock edge.
//   6. freq_word=8'h7F held -> period_len takes only the values 516 or 517; mean over 127 periods = 65536/127.

Source files
------------

// File: rtl/phase_accumulator_nco.sv
// Phase-accumulator NCO producing the PSI square wave for the frequency regulator loop.
// The increment word is latched only at accumulator wrap (or on start-up / zero-word stall),
// so the output phase stays continuous while the regulator retunes it.
module phase_accumulator_nco #(
    parameter int unsigned ACC_W     = 16,
    parameter logic [7:0]  INIT_WORD = 8'h7F,
    parameter int unsigned PER_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       freq_word,
    output logic             PSI,
    output logic             wrap_tick,
    output logic [ACC_W-1:0] phase,
    output logic [7:0]       active_word,
    output logic [PER_W-1:0] period_len,
    output logic             stalled
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [PER_W-1:0] per_cnt, per_cnt_nxt;
    logic [PER_W-1:0] per_inc;
    logic [PER_W-1:0] period_len_nxt;
    logic [7:0]       word_nxt;
    logic             tick_nxt;
    logic             stalled_nxt;
    logic [SUM_W-1:0] sum;
    logic             carry;

    // Accumulator adder with carry-out marking the wrap
    assign sum   = {1'b0, acc} + SUM_W'(active_word);
    assign carry = sum[ACC_W];

    // Saturating period counter increment
    assign per_inc = (per_cnt == '1) ? per_cnt : per_cnt + PER_W'(1);

    // Outputs taken straight from the accumulator register
    assign PSI   = acc[ACC_W-1];
    assign phase = acc;

    // Next-state and next-register values
    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        per_cnt_nxt    = per_cnt;
        period_len_nxt = period_len;
        word_nxt       = active_word;
        tick_nxt       = 1'b0;

        case (state)
            IDLE: begin
                acc_nxt     = '0;
                per_cnt_nxt = '0;
                if (en) begin
                    state_nxt = RUN;
                    word_nxt  = freq_word;
                end
            end
            RUN: begin
                if (!en) begin
                    // Disable wins over a coincident wrap: no tick, no reload
                    state_nxt   = IDLE;
                    acc_nxt     = '0;
                    per_cnt_nxt = '0;
                end else begin
                    acc_nxt = sum[ACC_W-1:0];
                    if (carry) begin
                        tick_nxt       = 1'b1;
                        period_len_nxt = per_inc;
                        per_cnt_nxt    = '0;
                        word_nxt       = freq_word;
                    end else begin
                        per_cnt_nxt = per_inc;
                        // A zero word never wraps, so keep sampling to escape the stall
                        if (active_word == '0) begin
                            word_nxt = freq_word;
                        end
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                acc_nxt     = '0;
                per_cnt_nxt = '0;
            end
        endcase

        stalled_nxt = (state_nxt == RUN) && (word_nxt == '0);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            per_cnt     <= '0;
            period_len  <= '0;
            active_word <= INIT_WORD;
            wrap_tick   <= 1'b0;
            stalled     <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            per_cnt     <= per_cnt_nxt;
            period_len  <= period_len_nxt;
            active_word <= word_nxt;
            wrap_tick   <= tick_nxt;
            stalled     <= stalled_nxt;
        end
    end

endmodule

// File: tb/tb_phase_accumulator_nco.sv
// Directed self-checking bench for phase_accumulator_nco.
module tb_phase_accumulator_nco;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  freq_word;
    logic        PSI;
    logic        wrap_tick;
    logic [15:0] phase;
    logic [7:0]  active_word;
    logic [15:0] period_len;
    logic        stalled;

    int checks = 0;
    int errors = 0;

    phase_accumulator_nco dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .freq_word   (freq_word),
        .PSI         (PSI),
        .wrap_tick   (wrap_tick),
        .phase       (phase),
        .active_word (active_word),
        .period_len  (period_len),
        .stalled     (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Advance one clock; sample and drive 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until wrap_tick is seen or the budget runs out
    task automatic wait_wrap(input int budget, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            cycles++;
            if (wrap_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; freq_word = 8'h00;
        #12;
        checks++; if (PSI !== 1'b0)         begin errors++; $display("FAIL reset_psi: got %b expected 0", PSI); end
        checks++; if (phase !== 16'h0000)   begin errors++; $display("FAIL reset_phase: got %h expected 0000", phase); end
        checks++; if (wrap_tick !== 1'b0)   begin errors++; $display("FAIL reset_tick: got %b expected 0", wrap_tick); end
        checks++; if (active_word !== 8'h7F) begin errors++; $display("FAIL reset_word: got %h expected 7f", active_word); end
        checks++; if (period_len !== 16'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period_len); end
        checks++; if (stalled !== 1'b0)     begin errors++; $display("FAIL reset_stalled: got %b expected 0", stalled); end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (phase !== 16'h0000)   begin errors++; $display("FAIL idle_phase: got %h expected 0000", phase); end
        checks++; if (active_word !== 8'h7F) begin errors++; $display("FAIL idle_word: got %h expected 7f", active_word); end
    endtask

    task automatic test_basic_period();
        int  lows;
        int  highs;
        int  cycles;
        bit  ok;
        bit  stray_tick;
        logic [15:0] first_phase;
        lows = 0; highs = 0; stray_tick = 1'b0; first_phase = 16'h0;
        freq_word = 8'h80; en = 1'b1;
        tick();
        checks++; if (active_word !== 8'h80) begin errors++; $display("FAIL start_word: got %h expected 80", active_word); end
        checks++; if (phase !== 16'h0000)    begin errors++; $display("FAIL start_phase: got %h expected 0000", phase); end
        if (PSI) highs++; else lows++;
        for (int i = 1; i < 512; i++) begin
            tick();
            if (i == 1) first_phase = phase;
            if (PSI) highs++; else lows++;
            if (wrap_tick !== 1'b0) stray_tick = 1'b1;
        end
        checks++; if (first_phase !== 16'h0080) begin errors++; $display("FAIL first_step: got %h expected 0080", first_phase); end
        checks++; if (lows !== 256)  begin errors++; $display("FAIL psi_low: got %0d expected 256", lows); end
        checks++; if (highs !== 256) begin errors++; $display("FAIL psi_high: got %0d expected 256", highs); end
        checks++; if (stray_tick !== 1'b0) begin errors++; $display("FAIL early_tick: got %b expected 0", stray_tick); end
        tick();
        checks++; if (wrap_tick !== 1'b1)   begin errors++; $display("FAIL wrap_tick: got %b expected 1", wrap_tick); end
        checks++; if (phase !== 16'h0000)   begin errors++; $display("FAIL wrap_phase: got %h expected 0000", phase); end
        checks++; if (period_len !== 16'd512) begin errors++; $display("FAIL period1: got %0d expected 512", period_len); end
        tick();
        checks++; if (wrap_tick !== 1'b0)   begin errors++; $display("FAIL tick_width: got %b expected 0", wrap_tick); end
        wait_wrap(600, cycles, ok);
        checks++; if (!ok || cycles !== 511) begin errors++; $display("FAIL wrap_spacing: got %0d (ok=%b) expected 511", cycles, ok); end
        checks++; if (period_len !== 16'd512) begin errors++; $display("FAIL period2: got %0d expected 512", period_len); end
    endtask

    task automatic test_word_change();
        int cycles;
        bit ok;
        repeat (100) tick();
        freq_word = 8'h40;
        tick();
        checks++; if (active_word !== 8'h80) begin errors++; $display("FAIL no_midreload: got %h expected 80", active_word); end
        wait_wrap(600, cycles, ok);
        checks++; if (!ok || cycles !== 411) begin errors++; $display("FAIL cur_period_wrap: got %0d (ok=%b) expected 411", cycles, ok); end
        checks++; if (period_len !== 16'd512) begin errors++; $display("FAIL cur_period: got %0d expected 512", period_len); end
        checks++; if (active_word !== 8'h40) begin errors++; $display("FAIL reload_word: got %h expected 40", active_word); end
        tick();
        checks++; if (phase !== 16'h0040) begin errors++; $display("FAIL new_step: got %h expected 0040", phase); end
        wait_wrap(1100, cycles, ok);
        checks++; if (!ok || cycles !== 1023) begin errors++; $display("FAIL next_period_wrap: got %0d (ok=%b) expected 1023", cycles, ok); end
        checks++; if (period_len !== 16'd1024) begin errors++; $display("FAIL next_period: got %0d expected 1024", period_len); end
    endtask

    task automatic test_zero_word();
        int cycles;
        bit ok;
        freq_word = 8'h00;
        wait_wrap(1100, cycles, ok);
        checks++; if (!ok || cycles !== 1024) begin errors++; $display("FAIL zero_wrap: got %0d (ok=%b) expected 1024", cycles, ok); end
        checks++; if (active_word !== 8'h00) begin errors++; $display("FAIL zero_word: got %h expected 00", active_word); end
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL stall_set: got %b expected 1", stalled); end
        repeat (3) tick();
        checks++; if (phase !== 16'h0000) begin errors++; $display("FAIL stall_frozen: got %h expected 0000", phase); end
        checks++; if (wrap_tick !== 1'b0) begin errors++; $display("FAIL stall_tick: got %b expected 0", wrap_tick); end
        freq_word = 8'h80;
        tick();
        checks++; if (stalled !== 1'b0)      begin errors++; $display("FAIL stall_clear: got %b expected 0", stalled); end
        checks++; if (active_word !== 8'h80) begin errors++; $display("FAIL stall_reload: got %h expected 80", active_word); end
        checks++; if (phase !== 16'h0000)    begin errors++; $display("FAIL stall_exit_phase: got %h expected 0000", phase); end
        tick();
        checks++; if (phase !== 16'h0080) begin errors++; $display("FAIL resume1: got %h expected 0080", phase); end
        tick();
        checks++; if (phase !== 16'h0100) begin errors++; $display("FAIL resume2: got %h expected 0100", phase); end
    endtask

    task automatic test_disable();
        int cycles;
        bit ok;
        repeat (300) tick();
        checks++; if (PSI !== 1'b1) begin errors++; $display("FAIL pre_disable_psi: got %b expected 1", PSI); end
        en = 1'b0;
        tick();
        checks++; if (PSI !== 1'b0)          begin errors++; $display("FAIL disable_psi: got %b expected 0", PSI); end
        checks++; if (phase !== 16'h0000)    begin errors++; $display("FAIL disable_phase: got %h expected 0000", phase); end
        checks++; if (wrap_tick !== 1'b0)    begin errors++; $display("FAIL disable_tick: got %b expected 0", wrap_tick); end
        checks++; if (period_len !== 16'd1024) begin errors++; $display("FAIL disable_period: got %0d expected 1024", period_len); end
        checks++; if (active_word !== 8'h80) begin errors++; $display("FAIL disable_word: got %h expected 80", active_word); end
        repeat (5) tick();
        checks++; if (phase !== 16'h0000) begin errors++; $display("FAIL idle_hold: got %h expected 0000", phase); end
        en = 1'b1;
        tick();
        wait_wrap(600, cycles, ok);
        checks++; if (!ok || cycles !== 512) begin errors++; $display("FAIL restart_wrap: got %0d (ok=%b) expected 512", cycles, ok); end
        checks++; if (period_len !== 16'd512) begin errors++; $display("FAIL restart_period: got %0d expected 512", period_len); end
    endtask

    task automatic test_wrap_vs_disable();
        freq_word = 8'h40;
        repeat (511) tick();
        checks++; if (phase !== 16'hFF80) begin errors++; $display("FAIL prewrap_phase: got %h expected ff80", phase); end
        en = 1'b0;
        tick();
        checks++; if (wrap_tick !== 1'b0)     begin errors++; $display("FAIL coinc_tick: got %b expected 0", wrap_tick); end
        checks++; if (phase !== 16'h0000)     begin errors++; $display("FAIL coinc_phase: got %h expected 0000", phase); end
        checks++; if (period_len !== 16'd512) begin errors++; $display("FAIL coinc_period: got %0d expected 512", period_len); end
        checks++; if (active_word !== 8'h80)  begin errors++; $display("FAIL coinc_word: got %h expected 80", active_word); end
    endtask

    task automatic test_async_reset();
        freq_word = 8'h80; en = 1'b1;
        tick();
        repeat (300) tick();
        checks++; if (PSI !== 1'b1) begin errors++; $display("FAIL prereset_psi: got %b expected 1", PSI); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (PSI !== 1'b0)           begin errors++; $display("FAIL arst_psi: got %b expected 0", PSI); end
        checks++; if (phase !== 16'h0000)     begin errors++; $display("FAIL arst_phase: got %h expected 0000", phase); end
        checks++; if (active_word !== 8'h7F)  begin errors++; $display("FAIL arst_word: got %h expected 7f", active_word); end
        checks++; if (period_len !== 16'd0)   begin errors++; $display("FAIL arst_period: got %0d expected 0", period_len); end
        en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fractional_word();
        int cycles;
        bit ok;
        int n517;
        int total;
        logic [15:0] exp_len;
        n517 = 0; total = 0;
        freq_word = 8'h7F; en = 1'b1;
        tick();
        // From phase 0 with step 127: first period 517, then 30 of 516, then 517
        for (int p = 0; p < 32; p++) begin
            wait_wrap(600, cycles, ok);
            exp_len = (p == 0 || p == 31) ? 16'd517 : 16'd516;
            checks++;
            if (!ok || period_len !== exp_len) begin
                errors++;
                $display("FAIL frac_period[%0d]: got %0d (ok=%b) expected %0d", p, period_len, ok, exp_len);
            end
            if (period_len == 16'd517) n517++;
            total += int'(period_len);
        end
        checks++; if (n517 !== 2)     begin errors++; $display("FAIL frac_count517: got %0d expected 2", n517); end
        checks++; if (total !== 16514) begin errors++; $display("FAIL frac_total: got %0d expected 16514", total); end
    endtask

    initial begin
        test_reset();
        test_basic_period();
        test_word_change();
        test_zero_word();
        test_disable();
        test_wrap_vs_disable();
        test_async_reset();
        test_fractional_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
